// File: rtl/hack_spi_pkg.sv
// ---------------------------------------------------------------------------
// hack_spi_pkg
// Shared definitions for the 23LC1024 SPI SRAM master:
//   - SPI opcodes (sequential-mode read / write)
//   - controller state encoding
//   - frame length and a helper that assembles the 48-bit command frame
// ---------------------------------------------------------------------------
package hack_spi_pkg;

    localparam int FRAME_BITS = 48;

    localparam logic [7:0] SPI_READ  = 8'h03;
    localparam logic [7:0] SPI_WRITE = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Frame layout, MSB first: opcode[47:40], byte address[39:16], data[15:0].
    // Reads carry zeros in the data slot so SI stays low while the RAM talks.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        write,
        input logic [23:0] byte_addr,
        input logic [15:0] wdata
    );
        logic [7:0]  op_v;
        logic [15:0] data_v;
        if (write) begin
            op_v   = SPI_WRITE;
            data_v = wdata;
        end else begin
            op_v   = SPI_READ;
            data_v = 16'h0000;
        end
        build_frame = {op_v, byte_addr, data_v};
    endfunction

endpackage

// File: rtl/spi_shift_48.sv
// ---------------------------------------------------------------------------
// spi_shift_48
// Parallel-load 48-bit transmit shifter plus 16-bit receive shifter.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   load           : load load_frame into the TX shifter
//   load_frame     : 48-bit frame, bit 47 goes out first
//   shift_tx       : advance TX by one bit (shift left, zero fill)
//   sample_rx      : shift rx_in into the RX register LSB
//   rx_in          : serial data from the RAM
//   tx_bit         : current TX bit (register output, drives SI directly)
//   rx_word        : last 16 sampled bits, first sampled bit in MSB
// ---------------------------------------------------------------------------
module spi_shift_48
    import hack_spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_frame,
    input  logic                  shift_tx,
    input  logic                  sample_rx,
    input  logic                  rx_in,
    output logic                  tx_bit,
    output logic [15:0]           rx_word
);

    logic [FRAME_BITS-1:0] tx_r;
    logic [15:0]           rx_r;

    // TX shifter: zero fill means the register is empty (SI low) once all
    // 48 bits have been shifted out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_r <= {FRAME_BITS{1'b0}};
        end else if (load) begin
            tx_r <= load_frame;
        end else if (shift_tx) begin
            tx_r <= {tx_r[FRAME_BITS-2:0], 1'b0};
        end else begin
            tx_r <= tx_r;
        end
    end

    // RX shifter: samples every bit of the frame; only the last 16 survive,
    // which are exactly the data bits of a read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_r <= 16'h0000;
        end else if (sample_rx) begin
            rx_r <= {rx_r[14:0], rx_in};
        end else begin
            rx_r <= rx_r;
        end
    end

    assign tx_bit  = tx_r[FRAME_BITS-1];
    assign rx_word = rx_r;

endmodule

// File: rtl/spi_ram_master.sv
// ---------------------------------------------------------------------------
// spi_ram_master
// Single-word (16-bit) read/write master for a 23LC1024 SPI SRAM in
// single-SPI sequential mode, SPI mode 0, SCK = clk/2.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake, accepted when both high
//   req_write            : 1 = write, 0 = read
//   req_addr             : word address (byte address = {req_addr, 0})
//   req_wdata            : write data
//   rsp_valid            : one-cycle completion pulse
//   rsp_rdata            : last read word
//   sram_cs_n/sck/si/so  : SPI pins (SIO0 = si, SIO1 = so)
//   sram_hold_n          : tied high
// Timing: accept edge -> START(1) -> SHIFT(96) -> STOP(1) -> IDLE,
// so rsp_valid is high in the 98th cycle and accesses repeat every 99.
// ---------------------------------------------------------------------------
module spi_ram_master
    import hack_spi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int RAM_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [RAM_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic [RAM_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      sram_cs_n,
    output logic                      sram_sck,
    output logic                      sram_si,
    input  logic                      sram_so,
    output logic                      sram_hold_n
);

    state_t                    state_r;
    logic [5:0]                bit_cnt_r;
    logic                      phase_r;
    logic                      write_r;
    logic                      req_ready_r;
    logic                      rsp_valid_r;
    logic [RAM_DATA_WIDTH-1:0] rsp_rdata_r;
    logic                      cs_n_r;
    logic                      sck_r;

    logic                      accept_s;
    logic                      shift_tx_s;
    logic                      sample_rx_s;
    logic [23:0]               byte_addr_s;
    logic [FRAME_BITS-1:0]     frame_s;
    logic                      tx_bit_s;
    logic [15:0]               rx_word_s;

    // Byte address is the word address shifted left once, zero-extended.
    always_comb begin
        byte_addr_s                 = 24'h000000;
        byte_addr_s[ADDR_WIDTH:0]   = {req_addr, 1'b0};
    end

    assign frame_s = build_frame(req_write, byte_addr_s, req_wdata);

    // Handshake and shifter strobes. SI changes only on the edge that drops
    // SCK (leaving phase 1); SO is sampled on the edge that raises SCK.
    always_comb begin
        accept_s    = req_valid && req_ready_r && (state_r == ST_IDLE);
        shift_tx_s  = (state_r == ST_SHIFT) && phase_r;
        sample_rx_s = (state_r == ST_SHIFT) && !phase_r;
    end

    spi_shift_48 u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (accept_s),
        .load_frame (frame_s),
        .shift_tx   (shift_tx_s),
        .sample_rx  (sample_rx_s),
        .rx_in      (sram_so),
        .tx_bit     (tx_bit_s),
        .rx_word    (rx_word_s)
    );

    // Frame sequencer; all SPI pins and response signals are flops that are
    // set on the edge entering the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 6'd0;
            phase_r     <= 1'b0;
            write_r     <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {RAM_DATA_WIDTH{1'b0}};
            cs_n_r      <= 1'b1;
            sck_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    sck_r       <= 1'b0;
                    phase_r     <= 1'b0;
                    if (accept_s) begin
                        state_r     <= ST_START;
                        write_r     <= req_write;
                        req_ready_r <= 1'b0;
                        cs_n_r      <= 1'b0;
                    end else begin
                        req_ready_r <= 1'b1;
                        cs_n_r      <= 1'b1;
                    end
                end
                ST_START: begin
                    state_r   <= ST_SHIFT;
                    phase_r   <= 1'b0;
                    bit_cnt_r <= 6'd47;
                    sck_r     <= 1'b0;
                end
                ST_SHIFT: begin
                    if (!phase_r) begin
                        phase_r <= 1'b1;
                        sck_r   <= 1'b1;
                    end else begin
                        phase_r <= 1'b0;
                        sck_r   <= 1'b0;
                        if (bit_cnt_r == 6'd0) begin
                            // Last SCK high phase done: rx_word_s now holds
                            // all 16 data bits (sampled on the rising edge).
                            state_r     <= ST_STOP;
                            cs_n_r      <= 1'b1;
                            rsp_valid_r <= 1'b1;
                            if (!write_r) begin
                                rsp_rdata_r <= rx_word_s;
                            end else begin
                                rsp_rdata_r <= rsp_rdata_r;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 6'd1;
                        end
                    end
                end
                ST_STOP: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    cs_n_r      <= 1'b1;
                    sck_r       <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    cs_n_r      <= 1'b1;
                    sck_r       <= 1'b0;
                    phase_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign sram_cs_n   = cs_n_r;
    assign sram_sck    = sck_r;
    assign sram_si     = tx_bit_s;
    assign sram_hold_n = 1'b1;

endmodule
